// File: rtl/frac_pwm_ctrl_if.sv
// Configuration channel between the host register block and frac_pwm_ctrl.
// One offer carries a period divider, a target duty and a slew step.
interface frac_pwm_ctrl_if #(
  parameter int WIDTH = 17,
  parameter int FSZE  = 3
) ();
  logic                  valid;
  logic                  ready;
  logic [WIDTH-1:0]      no;
  logic [WIDTH+FSZE-1:0] duty;
  logic [WIDTH+FSZE-1:0] step;

  modport master (output valid, no, duty, step, input ready);
  modport slave  (input valid, no, duty, step, output ready);
endinterface

// File: rtl/frac_pwm_ctrl.sv
// Setpoint sequencer for the fractional PWM core.
// Accepts configs into a one-deep shadow, applies them only at frame
// boundaries and slews the fractional duty towards the target so the core
// never sees a mid-frame change.
module frac_pwm_ctrl #(
  parameter int WIDTH  = 17,
  parameter int FSZE   = 3,
  parameter int DEF_NO = 1000
) (
  input  logic             sys_clk,
  input  logic             sync_rst_n,
  input  logic             en,
  frac_pwm_ctrl_if.slave   cfg,
  output logic [WIDTH-1:0] pwm_no,
  output logic [WIDTH-1:0] pwm_n,
  output logic [WIDTH-1:0] pwm_mf,
  output logic             frame_tick,
  output logic             at_target,
  output logic             busy
);

  localparam int DW = WIDTH + FSZE;
  localparam logic [WIDTH-1:0] DEF_NO_W = DEF_NO[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, RAMP, TRACK, STOP} state_t;

  state_t          state;
  logic [WIDTH-1:0] frame_cnt;
  logic [WIDTH-1:0] act_no;
  logic [DW-1:0]    eff_tgt;
  logic [DW-1:0]    act_step;
  logic [DW-1:0]    duty_cur;
  logic             pending;
  logic             ready_q;
  logic [WIDTH-1:0] sh_no;
  logic [DW-1:0]    sh_tgt;
  logic [DW-1:0]    sh_step;

  logic             boundary;
  logic             apply;
  logic [WIDTH-1:0] nxt_no;
  logic [DW-1:0]    nxt_step;
  logic [DW-1:0]    sh_no_q;
  logic [DW-1:0]    nxt_eff;
  logic [DW-1:0]    dest;
  logic [DW:0]      sum;
  logic [DW-1:0]    diff;
  logic [DW-1:0]    duty_upd;

  // Boundary decode, config hand-over values and the slew-limited next duty.
  // A config applied at a boundary already governs that boundary's duty step,
  // so a step of 0 lands on the new target in the same frame it takes effect.
  always_comb begin
    boundary = (frame_cnt == '0);
    apply    = boundary && pending;
    nxt_no   = apply ? sh_no : act_no;
    nxt_step = apply ? sh_step : act_step;
    sh_no_q  = {sh_no, {FSZE{1'b0}}};
    nxt_eff  = eff_tgt;
    if (apply) begin
      nxt_eff = (sh_tgt > sh_no_q) ? sh_no_q : sh_tgt;
    end
    dest     = (state == STOP) ? '0 : nxt_eff;
    sum      = {1'b0, duty_cur} + {1'b0, nxt_step};
    diff     = duty_cur - dest;
    duty_upd = dest;
    if (nxt_step != '0) begin
      if (duty_cur < dest) begin
        duty_upd = (sum > {1'b0, dest}) ? dest : sum[DW-1:0];
      end else if (duty_cur > dest) begin
        duty_upd = (diff > nxt_step) ? (duty_cur - nxt_step) : dest;
      end
    end
  end

  // Frame counter, shadow/active config registers, duty register and state machine.
  always_ff @(posedge sys_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state     <= IDLE;
      frame_cnt <= DEF_NO_W;
      act_no    <= DEF_NO_W;
      eff_tgt   <= '0;
      act_step  <= '0;
      duty_cur  <= '0;
      pending   <= 1'b0;
      ready_q   <= 1'b1;
      sh_no     <= '0;
      sh_tgt    <= '0;
      sh_step   <= '0;
    end else begin
      frame_cnt <= boundary ? nxt_no : frame_cnt - 1'b1;

      if (apply) begin
        act_no   <= sh_no;
        eff_tgt  <= nxt_eff;
        act_step <= sh_step;
        pending  <= 1'b0;
        ready_q  <= 1'b1;
      end else if (cfg.valid && ready_q) begin
        sh_no   <= cfg.no;
        sh_tgt  <= cfg.duty;
        sh_step <= cfg.step;
        pending <= 1'b1;
        ready_q <= 1'b0;
      end

      if (boundary && state != IDLE) begin
        duty_cur <= duty_upd;
      end

      case (state)
        IDLE: begin
          duty_cur <= '0;
          if (en) state <= RAMP;
        end
        RAMP, TRACK: begin
          if (!en) state <= STOP;
          else if (boundary) state <= (duty_upd == nxt_eff) ? TRACK : RAMP;
        end
        STOP: begin
          if (en) state <= RAMP;
          else if (boundary ? (duty_upd == '0) : (duty_cur == '0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cfg.ready  = ready_q;
  assign pwm_no     = act_no;
  assign pwm_n      = duty_cur[DW-1:FSZE];
  assign pwm_mf     = {{(WIDTH-FSZE){1'b0}}, duty_cur[FSZE-1:0]};
  assign frame_tick = boundary;
  assign at_target  = (state == TRACK);
  assign busy       = (state == RAMP) || (state == STOP);

endmodule
